serial_add_ctrl: RTL

Bit-serial adder controller. It shares one single-bit full-adder cell across an N-bit addition, sequencing operand bits LSB-first through the cell with a registered carry. A push-key style START launches each operation; a single-cycle DONE pulse presents the result. The block sits between board key/switch inputs and the LED/display drivers.

---
 rtl/serial_add_pkg.sv | 11 +
 rtl/fulladdersec.sv | 13 +
 rtl/serial_add_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// State encoding shared by the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/fulladdersec.sv
// One-bit full-adder cell, shared across all bit positions of the serial add.
module fulladdersec (
  input  logic KEY1,
  input  logic KEY2,
  input  logic KEY3,
  output logic SUM,
  output logic C
);

  assign SUM = KEY1 ^ KEY2 ^ KEY3;
  assign C   = (KEY1 & KEY2) | (KEY1 & KEY3) | (KEY2 & KEY3);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first, one bit per clock.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic             start_dly_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, s_nxt;
  logic             carry_q;
  logic             cell_s, cell_c;
  logic             launch, last_bit;

  assign launch   = START & ~start_dly_q;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  fulladdersec u_cell (
    .KEY1 (a_sr_q[0]),
    .KEY2 (b_sr_q[0]),
    .KEY3 (carry_q),
    .SUM  (cell_s),
    .C    (cell_c)
  );

  // The sum register fills from the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_s1
      assign s_nxt = cell_s;
    end else begin : g_sn
      assign s_nxt = {cell_s, s_sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      start_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= START;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (launch) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SHIFT;
      ST_SHIFT:  if (last_bit) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      SUM     <= '0;
      COUT    <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          a_sr_q  <= A;
          b_sr_q  <= B;
          carry_q <= CIN;
          s_sr_q  <= '0;
          cnt_q   <= '0;
        end
        ST_SHIFT: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          s_sr_q  <= s_nxt;
          carry_q <= cell_c;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            SUM  <= s_nxt;
            COUT <= cell_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign DONE = (state_q == ST_FINISH);

endmodule
